bus_in_port: RTL and testbench

- Input-port stage directly upstream of the processor's bus_in/hs_in/hs_out interface.
- Buffers bytes from an external producer (valid/ready) in a small FIFO.
- Delivers one byte per processor request using a four-phase handshake: processor drives hs_out, port drives hs_in.
- Processor latches bus_in into RIN while hs_in is high.

---
 rtl/bus_in_port.sv | 152 +++++++++++++++
 tb/tb_bus_in_port.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_in_port.sv
// bus_in_port: input-port stage feeding a processor's bus_in/hs_in/hs_out
// interface. Bytes from an external valid/ready producer are buffered in a
// small FIFO and delivered one per processor request with a four-phase
// handshake (processor drives hs_out, this port answers on hs_in).
//
// Optional feature, macro INPORT_IRQ_EN: when defined, irq is a registered
// fill-level interrupt (set while idle with at least IRQ_LEVEL bytes queued).
// When undefined, irq is tied low and no interrupt logic is built.

module bus_in_port #(
    parameter int D_WIDTH   = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int IRQ_LEVEL = 1
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic [D_WIDTH-1:0] ext_data,
    input  logic               ext_valid,
    output logic               ext_ready,
    input  logic               hs_out,
    output logic [D_WIDTH-1:0] bus_in,
    output logic               hs_in,
    output logic [AW:0]        count,
    output logic               irq
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    // Reject inconsistent configurations at elaboration time.
    if (((1 << AW) != DEPTH) || (DEPTH < 2) || (IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_bad_params
        $error("bus_in_port: DEPTH must equal 2**AW (>=2) and IRQ_LEVEL must be in 1..DEPTH");
    end

    logic [D_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    state_t             state_q;
    logic [D_WIDTH-1:0] bus_in_q;
    logic               hs_in_q;
    logic               push;
    logic               pop;

    // Full is judged from the registered count only, so a pop on the same
    // edge never lets a push into a full FIFO.
    assign ext_ready = (count_q != FULL_CNT);
    assign push      = ext_valid & ext_ready;
    // A request is only honoured from IDLE and only when a byte is queued.
    assign pop       = (state_q == IDLE) & hs_out & (count_q != '0);

    assign bus_in = bus_in_q;
    assign hs_in  = hs_in_q;
    assign count  = count_q;

    // Occupancy next-state: push and pop on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    // Write pointer and occupancy; the pointer wraps naturally at DEPTH.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ONE_PTR;
            end
            count_q <= count_d;
        end
    end

    // Handshake FSM with registered bus_in/hs_in; also owns the read pointer.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            bus_in_q <= '0;
            hs_in_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        bus_in_q <= mem_q[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + ONE_PTR;
                        hs_in_q  <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    // bus_in is left holding the last byte after release.
                    if (!hs_out) begin
                        hs_in_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    hs_in_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef INPORT_IRQ_EN
    localparam logic [AW:0] IRQ_CNT = (AW + 1)'(IRQ_LEVEL);

    logic irq_q;
    logic idle_d;

    // Next-state is IDLE when no request is taken from IDLE or ACK releases.
    always_comb begin
        idle_d = ((state_q == IDLE) && !pop) || ((state_q == ACK) && !hs_out);
    end

    // Interrupt only while idle with enough bytes queued, so software is not
    // prompted during a transfer it is already servicing.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= idle_d && (count_d >= IRQ_CNT);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bus_in_port.sv
// Directed bench for bus_in_port: reset, single transfer, full/wrap,
// stall on empty, simultaneous push/pop, back-to-back, reset mid-transfer.
`timescale 1ns/1ps

module tb_bus_in_port;

    logic       g_clk;
    logic       g_clr;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       hs_out;
    logic [7:0] bus_in;
    logic       hs_in;
    logic [2:0] count;
    logic       irq;

    int checks;
    int errors;

`ifdef INPORT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    bus_in_port #(
        .D_WIDTH   (8),
        .DEPTH     (4),
        .AW        (2),
        .IRQ_LEVEL (2)
    ) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .hs_out    (hs_out),
        .bus_in    (bus_in),
        .hs_in     (hs_in),
        .count     (count),
        .irq       (irq)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Stimulus: one push, leaves time at posedge+1.
    task automatic push(input logic [7:0] d);
        ext_data  = d;
        ext_valid = 1'b1;
        @(posedge g_clk);
        #1;
        ext_valid = 1'b0;
    endtask

    // Stimulus: one full handshake with a bounded wait for hs_in.
    task automatic xfer(output logic [7:0] b, output bit ok);
        int n;
        ok     = 1'b0;
        b      = 8'h00;
        hs_out = 1'b1;
        n      = 0;
        do begin
            @(posedge g_clk);
            #1;
            n++;
        end while (hs_in !== 1'b1 && n < 20);
        if (hs_in === 1'b1) begin
            b  = bus_in;
            ok = 1'b1;
        end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
        if (hs_in !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge g_clk);
        #3;
        g_clr = 1'b0;
        #1;
        checks++; if (bus_in !== 8'h00) begin errors++; $display("FAIL rst_bus_in got %h want 00", bus_in); end
        checks++; if (hs_in !== 1'b0) begin errors++; $display("FAIL rst_hs_in got %b want 0", hs_in); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_ext_ready got %b want 1", ext_ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
        @(negedge g_clk);
        g_clr = 1'b1;
        repeat (3) @(posedge g_clk);
        #1;
        checks++; if (bus_in !== 8'h00) begin errors++; $display("FAIL idle_bus_in got %h want 00", bus_in); end
        checks++; if (hs_in !== 1'b0) begin errors++; $display("FAIL idle_hs_in got %b want 0", hs_in); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count got %0d want 0", count); end
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL idle_ext_ready got %b want 1", ext_ready); end
    endtask

    task automatic test_single;
        push(8'hA5);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_push got %0d want 1", count); end
        hs_out = 1'b1;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b1) begin errors++; $display("FAIL single_hs_in_rise got %b want 1", hs_in); end
        checks++; if (bus_in !== 8'hA5) begin errors++; $display("FAIL single_bus_in got %h want a5", bus_in); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_pop got %0d want 0", count); end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b0) begin errors++; $display("FAIL single_hs_in_fall got %b want 0", hs_in); end
        checks++; if (bus_in !== 8'hA5) begin errors++; $display("FAIL single_bus_in_hold got %h want a5", bus_in); end
    endtask

    task automatic test_full_wrap;
        logic [7:0] exp [4];
        logic [7:0] b;
        bit         ok;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) push(exp[i]);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL full_ext_ready got %b want 0", ext_ready); end
        push(8'h55);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            xfer(b, ok);
            checks++;
            if (!ok || b !== exp[i]) begin
                errors++;
                $display("FAIL full_order[%0d] got %h (hs ok %b) want %h", i, b, ok, exp[i]);
            end
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain_count got %0d want 0", count); end
        push(8'h66);
        xfer(b, ok);
        checks++; if (!ok || b !== 8'h66) begin errors++; $display("FAIL wrap_byte got %h (hs ok %b) want 66", b, ok); end
    endtask

    task automatic test_stall;
        int highs;
        logic [7:0] b;
        highs  = 0;
        hs_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge g_clk);
            #1;
            if (hs_in !== 1'b0) highs++;
        end
        checks++; if (highs != 0) begin errors++; $display("FAIL stall_hs_in got %0d high cycles want 0", highs); end
        push(8'h7E);
        checks++; if (hs_in !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL stall_push_edge got hs_in %b count %0d want 0/1", hs_in, count); end
        @(posedge g_clk);
        #1;
        b = bus_in;
        checks++; if (hs_in !== 1'b1 || b !== 8'h7E) begin errors++; $display("FAIL stall_serve got hs_in %b bus_in %h want 1/7e", hs_in, b); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stall_count got %0d want 0", count); end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_simul;
        logic [7:0] b;
        bit         ok;
        push(8'h01);
        push(8'h02);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_pre_count got %0d want 2", count); end
        ext_data  = 8'h03;
        ext_valid = 1'b1;
        hs_out    = 1'b1;
        @(posedge g_clk);
        #1;
        ext_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", count); end
        checks++; if (hs_in !== 1'b1 || bus_in !== 8'h01) begin errors++; $display("FAIL simul_byte got hs_in %b bus_in %h want 1/01", hs_in, bus_in); end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
        xfer(b, ok);
        checks++; if (!ok || b !== 8'h02) begin errors++; $display("FAIL simul_next1 got %h (hs ok %b) want 02", b, ok); end
        xfer(b, ok);
        checks++; if (!ok || b !== 8'h03) begin errors++; $display("FAIL simul_next2 got %h (hs ok %b) want 03", b, ok); end
    endtask

    task automatic test_back_to_back;
        push(8'hAA);
        push(8'hBB);
        hs_out = 1'b1;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b1 || bus_in !== 8'hAA) begin errors++; $display("FAIL b2b_first got hs_in %b bus_in %h want 1/aa", hs_in, bus_in); end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", hs_in); end
        hs_out = 1'b1;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b1 || bus_in !== 8'hBB) begin errors++; $display("FAIL b2b_second got hs_in %b bus_in %h want 1/bb", hs_in, bus_in); end
        hs_out = 1'b0;
        @(posedge g_clk);
        #1;
        checks++; if (count !== 3'd0 || hs_in !== 1'b0) begin errors++; $display("FAIL b2b_end got count %0d hs_in %b want 0/0", count, hs_in); end
    endtask

    task automatic test_reset_irq;
        push(8'h10);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_one got %b want 0", irq); end
        push(8'h20);
        checks++; if (irq !== IRQ_ON) begin errors++; $display("FAIL irq_two got %b want %b", irq, IRQ_ON); end
        hs_out = 1'b1;
        @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b1 || bus_in !== 8'h10) begin errors++; $display("FAIL irq_hs got hs_in %b bus_in %h want 1/10", hs_in, bus_in); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b want 0", irq); end
        #3;
        g_clr = 1'b0;
        #1;
        checks++; if (hs_in !== 1'b0 || count !== 3'd0 || irq !== 1'b0 || bus_in !== 8'h00)
            begin errors++; $display("FAIL midrst got hs_in %b count %0d irq %b bus_in %h want 0/0/0/00", hs_in, count, irq, bus_in); end
        hs_out = 1'b0;
        @(negedge g_clk);
        g_clr = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        checks++; if (hs_in !== 1'b0 || count !== 3'd0 || irq !== 1'b0)
            begin errors++; $display("FAIL midrst_release got hs_in %b count %0d irq %b want 0/0/0", hs_in, count, irq); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        g_clr     = 1'b1;
        ext_data  = 8'h00;
        ext_valid = 1'b0;
        hs_out    = 1'b0;
        test_reset;
        test_single;
        test_full_wrap;
        test_stall;
        test_simul;
        test_back_to_back;
        test_reset_irq;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
